// File: rtl/mem_exception_unit.sv
// Mem-stage exception arbiter ahead of CP0: picks the highest-priority cause,
// drives the CP0 exception strobes, flushes/redirects, then holds off for a refill.
module mem_exception_unit #(
  parameter int          SYNC_STAGES = 2,
  parameter int          HOLD_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hw_int,
  input  logic        timer_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_delayslot,
  input  logic        m_adel_if,
  input  logic        m_ri,
  input  logic        m_syscall,
  input  logic        m_break,
  input  logic        m_ov,
  input  logic        m_adel_d,
  input  logic        m_ades_d,
  input  logic [31:0] m_daddr,
  input  logic        m_eret,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
  output logic        exc_delayslot,
  output logic [31:0] exc_badvaddr,
  output logic [4:0]  exc_code,
  output logic        exc_eret,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  // state | meaning
  // IDLE  | arbitrating mem-stage causes, outputs live
  // HOLD  | post-flush holdoff, outputs forced to 0 while cnt runs down
  typedef enum logic {IDLE, HOLD} state_t;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [5:0]       sync_q [SYNC_STAGES];
  logic [5:0]       hw_sync;
  logic [7:0]       ip;
  logic             int_pend;
  logic             exc_hit;
  logic             take;
  logic [4:0]       code;
  logic [31:0]      badvaddr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign hw_sync  = sync_q[SYNC_STAGES-1];
  assign ip       = {hw_sync[5] | timer_int, hw_sync[4:0], cp0_cause[9:8]};
  assign int_pend = cp0_status[0] & ~cp0_status[1] & (|(ip & cp0_status[15:8]));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    exc_hit       = 1'b0;
    code          = 5'h00;
    badvaddr      = 32'h0;
    take          = 1'b0;
    exc_valid     = 1'b0;
    exc_pc        = 32'h0;
    exc_delayslot = 1'b0;
    exc_badvaddr  = 32'h0;
    exc_code      = 5'h00;
    exc_eret      = 1'b0;
    flush         = 1'b0;
    redirect_pc   = 32'h0;
    state_nxt     = state;
    cnt_nxt       = cnt;

    // Reset low masks the combinational path so nothing leaks into CP0.
    if (rst && state == IDLE && m_valid) begin
      exc_hit = 1'b1;
      if (int_pend)        code = 5'h00;
      else if (m_adel_if)  begin code = 5'h04; badvaddr = m_pc;    end
      else if (m_ri)       code = 5'h0A;
      else if (m_syscall)  code = 5'h08;
      else if (m_break)    code = 5'h09;
      else if (m_ov)       code = 5'h0C;
      else if (m_adel_d)   begin code = 5'h04; badvaddr = m_daddr; end
      else if (m_ades_d)   begin code = 5'h05; badvaddr = m_daddr; end
      else                 exc_hit = 1'b0;

      take = exc_hit | m_eret;
      if (take) begin
        exc_pc        = m_pc;
        exc_delayslot = m_delayslot;
        flush         = 1'b1;
      end
      if (exc_hit) begin
        exc_valid    = 1'b1;
        exc_code     = code;
        exc_badvaddr = badvaddr;
        redirect_pc  = EXC_VECTOR;
      end else if (m_eret) begin
        exc_eret    = 1'b1;
        redirect_pc = cp0_epc;
      end
    end

    case (state)
      IDLE: if (take) begin
        state_nxt = HOLD;
        cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
      end
      HOLD: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_exception_unit.sv
// Self-checking bench for mem_exception_unit: directed vector table plus
// hand-written sequences for holdoff, interrupt synchronisation, bubbles and reset.
module tb_mem_exception_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hw_int;
  logic        timer_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        m_valid, m_delayslot, m_adel_if, m_ri, m_syscall, m_break;
  logic        m_ov, m_adel_d, m_ades_d, m_eret;
  logic [31:0] m_pc, m_daddr;
  logic        exc_valid, exc_delayslot, exc_eret, flush;
  logic [31:0] exc_pc, exc_badvaddr, redirect_pc;
  logic [4:0]  exc_code;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;

  mem_exception_unit dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .timer_int(timer_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .m_valid(m_valid), .m_pc(m_pc), .m_delayslot(m_delayslot),
    .m_adel_if(m_adel_if), .m_ri(m_ri), .m_syscall(m_syscall), .m_break(m_break),
    .m_ov(m_ov), .m_adel_d(m_adel_d), .m_ades_d(m_ades_d), .m_daddr(m_daddr),
    .m_eret(m_eret),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_delayslot(exc_delayslot),
    .exc_badvaddr(exc_badvaddr), .exc_code(exc_code), .exc_eret(exc_eret),
    .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // fl bits: valid, ds, adel_if, ri, sys, brk, ov, adel_d, ades, eret
  // ex bits: exc_valid, exc_eret, flush
  typedef struct {
    string       name;
    logic [9:0]  fl;
    logic [31:0] pc, daddr, status, cause, epc;
    logic [2:0]  ex;
    logic [4:0]  code;
    logic [31:0] bad, redir, epc_out;
    logic        ds_out;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(string n, logic [9:0] fl, logic [31:0] pc, logic [31:0] daddr,
                              logic [31:0] status, logic [31:0] cause, logic [31:0] epc,
                              logic [2:0] ex, logic [4:0] code, logic [31:0] bad,
                              logic [31:0] redir, logic [31:0] epc_out, logic ds_out);
    vec_t v;
    v.name = n; v.fl = fl; v.pc = pc; v.daddr = daddr; v.status = status;
    v.cause = cause; v.epc = epc; v.ex = ex; v.code = code; v.bad = bad;
    v.redir = redir; v.epc_out = epc_out; v.ds_out = ds_out;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {m_valid, m_delayslot, m_adel_if, m_ri, m_syscall, m_break, m_ov, m_adel_d, m_ades_d, m_eret} = '0;
    m_pc = 32'h0; m_daddr = 32'h0; cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    hw_int = 6'h0; timer_int = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    {m_valid, m_delayslot, m_adel_if, m_ri, m_syscall, m_break, m_ov, m_adel_d, m_ades_d, m_eret} = v.fl;
    m_pc = v.pc; m_daddr = v.daddr; cp0_status = v.status; cp0_cause = v.cause; cp0_epc = v.epc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  initial begin
    vecs[0]  = mk("ov",          10'b1000001000, 32'h80000010, 32'h0,    32'h0,   32'h0,   32'h0,
                  3'b101, 5'h0C, 32'h0,        VEC,          32'h80000010, 1'b0);
    vecs[1]  = mk("ri_ades",     10'b1001000010, 32'h80000020, 32'h2000, 32'h0,   32'h0,   32'h0,
                  3'b101, 5'h0A, 32'h0,        VEC,          32'h80000020, 1'b0);
    vecs[2]  = mk("adel_d",      10'b1000000100, 32'h80000024, 32'h1003, 32'h0,   32'h0,   32'h0,
                  3'b101, 5'h04, 32'h1003,     VEC,          32'h80000024, 1'b0);
    vecs[3]  = mk("adel_if_ov",  10'b1010001000, 32'h80000003, 32'h0,    32'h0,   32'h0,   32'h0,
                  3'b101, 5'h04, 32'h80000003, VEC,          32'h80000003, 1'b0);
    vecs[4]  = mk("sys_brk_ds",  10'b1100110000, 32'h80000030, 32'h0,    32'h0,   32'h0,   32'h0,
                  3'b101, 5'h08, 32'h0,        VEC,          32'h80000030, 1'b1);
    vecs[5]  = mk("brk_ov",      10'b1000011000, 32'h80000034, 32'h0,    32'h0,   32'h0,   32'h0,
                  3'b101, 5'h09, 32'h0,        VEC,          32'h80000034, 1'b0);
    vecs[6]  = mk("ades",        10'b1000000010, 32'h80000038, 32'h2002, 32'h0,   32'h0,   32'h0,
                  3'b101, 5'h05, 32'h2002,     VEC,          32'h80000038, 1'b0);
    vecs[7]  = mk("eret",        10'b1000000001, 32'h80000040, 32'h0,    32'h0,   32'h0,   32'h80000200,
                  3'b011, 5'h00, 32'h0,        32'h80000200, 32'h80000040, 1'b0);
    vecs[8]  = mk("eret_sys",    10'b1000100001, 32'h80000044, 32'h0,    32'h0,   32'h0,   32'h80000200,
                  3'b101, 5'h08, 32'h0,        VEC,          32'h80000044, 1'b0);
    vecs[9]  = mk("bubble_sys",  10'b0000100000, 32'h80000048, 32'h0,    32'h0,   32'h0,   32'h0,
                  3'b000, 5'h00, 32'h0,        32'h0,        32'h0,        1'b0);
    vecs[10] = mk("sw_int",      10'b1000100000, 32'h8000004C, 32'h0,    32'h101, 32'h100, 32'h0,
                  3'b101, 5'h00, 32'h0,        VEC,          32'h8000004C, 1'b0);
    vecs[11] = mk("sw_int_exl",  10'b1001000000, 32'h80000050, 32'h0,    32'h103, 32'h100, 32'h0,
                  3'b101, 5'h0A, 32'h0,        VEC,          32'h80000050, 1'b0);
    vecs[12] = mk("sw_int_mask", 10'b1000000000, 32'h80000054, 32'h0,    32'h001, 32'h100, 32'h0,
                  3'b000, 5'h00, 32'h0,        32'h0,        32'h0,        1'b0);
    vecs[13] = mk("ie_off",      10'b1000000000, 32'h80000058, 32'h0,    32'h100, 32'h100, 32'h0,
                  3'b000, 5'h00, 32'h0,        32'h0,        32'h0,        1'b0);

    // Reset with a live cause on the inputs: nothing must reach CP0.
    clear_inputs();
    rst = 1'b0;
    m_valid = 1'b1; m_syscall = 1'b1; m_pc = 32'h80000000;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_exc_valid", exc_valid, 1'b0);
    chk("reset_flush", flush, 1'b0);
    chk("reset_redirect", redirect_pc, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk({vecs[i].name, ".exc_valid"}, exc_valid, vecs[i].ex[2]);
      chk({vecs[i].name, ".exc_eret"}, exc_eret, vecs[i].ex[1]);
      chk({vecs[i].name, ".flush"}, flush, vecs[i].ex[0]);
      chk({vecs[i].name, ".exc_code"}, exc_code, vecs[i].code);
      chk({vecs[i].name, ".badvaddr"}, exc_badvaddr, vecs[i].bad);
      chk({vecs[i].name, ".redirect_pc"}, redirect_pc, vecs[i].redir);
      chk({vecs[i].name, ".exc_pc"}, exc_pc, vecs[i].epc_out);
      chk({vecs[i].name, ".delayslot"}, exc_delayslot, vecs[i].ds_out);
      idle_cycles(2);
    end

    // Persistent overflow: one pulse, two held-off cycles, then re-taken.
    @(negedge clk);
    m_valid = 1'b1; m_ov = 1'b1; m_pc = 32'h80000010;
    #1;
    chk("hold.take", exc_valid, 1'b1);
    chk("hold.code", exc_code, 5'h0C);
    @(negedge clk); #1;
    chk("hold.c1_valid", exc_valid, 1'b0);
    chk("hold.c1_flush", flush, 1'b0);
    @(negedge clk); #1;
    chk("hold.c2_valid", exc_valid, 1'b0);
    chk("hold.c2_flush", flush, 1'b0);
    @(negedge clk); #1;
    chk("hold.retake", exc_valid, 1'b1);
    idle_cycles(2);

    // hw_int[0] pulse appears after exactly two synchroniser stages.
    @(negedge clk);
    cp0_status = 32'h401; m_valid = 1'b1; m_pc = 32'h80000060; hw_int = 6'h01;
    #1;
    chk("sync.t0", exc_valid, 1'b0);
    @(negedge clk);
    hw_int = 6'h00;
    #1;
    chk("sync.t1", exc_valid, 1'b0);
    @(negedge clk); #1;
    chk("sync.t2_valid", exc_valid, 1'b1);
    chk("sync.t2_code", exc_code, 5'h00);
    chk("sync.t2_redirect", redirect_pc, VEC);
    @(negedge clk); #1;
    chk("sync.t3", exc_valid, 1'b0);
    idle_cycles(3);

    // Same pulse with EXL set: masked.
    @(negedge clk);
    cp0_status = 32'h403; m_valid = 1'b1; m_pc = 32'h80000064; hw_int = 6'h01;
    @(negedge clk);
    hw_int = 6'h00;
    @(negedge clk); #1;
    chk("sync_exl.valid", exc_valid, 1'b0);
    chk("sync_exl.flush", flush, 1'b0);
    idle_cycles(3);

    // Timer interrupt lands on IP[7].
    @(negedge clk);
    cp0_status = 32'h8001; m_valid = 1'b1; m_pc = 32'h80000068; timer_int = 1'b1;
    #1;
    chk("timer.valid", exc_valid, 1'b1);
    chk("timer.code", exc_code, 5'h00);
    idle_cycles(2);

    // Pending interrupt waits through bubbles for the next real instruction.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cp0_status = 32'h201; cp0_cause = 32'h200; m_valid = 1'b0;
      #1;
      chk("bubble.valid", exc_valid, 1'b0);
      chk("bubble.flush", flush, 1'b0);
    end
    @(negedge clk);
    m_valid = 1'b1; m_pc = 32'h80000070;
    #1;
    chk("bubble.take", exc_valid, 1'b1);
    chk("bubble.code", exc_code, 5'h00);
    chk("bubble.pc", exc_pc, 32'h80000070);
    idle_cycles(2);

    // Reset during HOLD: back to IDLE, syscall taken right after release.
    @(negedge clk);
    m_valid = 1'b1; m_syscall = 1'b1; m_pc = 32'h80000080;
    #1;
    chk("rsthold.take", exc_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rsthold.in_reset", exc_valid, 1'b0);
    chk("rsthold.in_reset_flush", flush, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rsthold.retake", exc_valid, 1'b1);
    chk("rsthold.code", exc_code, 5'h08);
    chk("rsthold.redirect", redirect_pc, VEC);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
